// File: rtl/ultrasonic_echo_emulator.sv
// ultrasonic_echo_emulator
//  Synthesizable stand-in for an HC-SR04 ranging sensor. A trigger pulse of at
//  least MIN_TRIG_CYCLES is answered, after a fixed burst delay, with an echo
//  pulse whose width encodes the distance latched at trigger fall. Too-short
//  triggers are flagged on trig_err. After every echo a holdoff period ignores
//  further trigger activity.
//
//  Ports
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous active-low reset (assert async,
//                           release synchronised internally)
//   trigger        in   1   trigger from sensor controller, asynchronous
//   distance_cm    in   9   emulated distance, unsigned cm
//   object_present in   1   0 = no object, timeout-width echo
//   echo           out  1   echo pulse to sensor controller
//   busy           out  1   high whenever the FSM is not idle
//   trig_err       out  1   one-cycle pulse: trigger fell before minimum width
//   meas_count     out  16  completed echoes, wraps 0xFFFF -> 0
module ultrasonic_echo_emulator #(
  parameter int unsigned MIN_TRIG_CYCLES    = 500,
  parameter int unsigned BURST_DELAY_CYCLES = 10000,
  parameter int unsigned CYCLES_PER_CM      = 2900,
  parameter int unsigned MIN_CM             = 2,
  parameter int unsigned MAX_CM             = 400,
  parameter int unsigned TIMEOUT_CYCLES     = 1900000,
  parameter int unsigned HOLDOFF_CYCLES     = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [8:0]  distance_cm,
  input  logic        object_present,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic [15:0] meas_count
);

  // All cycle-count parameters are assumed to be at least 1.
  localparam logic [31:0] MIN_TRIG     = 32'(MIN_TRIG_CYCLES);
  localparam logic [31:0] BURST_LAST   = 32'(BURST_DELAY_CYCLES - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] CPC          = 32'(CYCLES_PER_CM);
  localparam logic [31:0] MIN_DIST     = 32'(MIN_CM);
  localparam logic [31:0] MAX_DIST     = 32'(MAX_CM);
  localparam logic [31:0] MIN_LEN      = 32'(MIN_CM * CYCLES_PER_CM);
  localparam logic [31:0] TIMEOUT_LEN  = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state;
  logic [1:0]  rst_pipe;
  logic        rst_int_n;
  logic        trig_m;
  logic        trig_s;
  logic        trig_q;
  logic        trig_rise;
  logic        trig_fall;
  logic [31:0] trig_width;
  logic [31:0] cnt;
  logic [8:0]  dist_q;
  logic        present_q;
  logic [31:0] dist_ext;
  logic [31:0] echo_len;
  logic [31:0] echo_last;

  // Reset asserts asynchronously everywhere but is released two clocks later,
  // so no flop sees rst_n rise close to an active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_m <= trigger;
      trig_s <= trig_m;
      trig_q <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_q;
  assign trig_fall = ~trig_s & trig_q;

  // Echo width from the latched distance; the multiply is full 32-bit.
  always_comb begin
    dist_ext = 32'(dist_q);
    if (!present_q || (dist_ext > MAX_DIST)) begin
      echo_len = TIMEOUT_LEN;
    end else if (dist_ext < MIN_DIST) begin
      echo_len = MIN_LEN;
    end else begin
      echo_len = dist_ext * CPC;
    end
    echo_last = echo_len - 32'd1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= IDLE;
      trig_width <= '0;
      cnt        <= '0;
      dist_q     <= '0;
      present_q  <= 1'b0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      trig_err   <= 1'b0;
      meas_count <= '0;
    end else begin
      trig_err <= 1'b0;
      case (state)
        IDLE: begin
          // Rise edge only: a trigger already high when holdoff ends is ignored.
          if (trig_rise) begin
            state      <= TRIG;
            busy       <= 1'b1;
            trig_width <= 32'd1;
          end
        end

        TRIG: begin
          if (trig_fall) begin
            if (trig_width >= MIN_TRIG) begin
              state     <= BURST;
              cnt       <= '0;
              dist_q    <= distance_cm;
              present_q <= object_present;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              trig_err <= 1'b1;
            end
          end else if (trig_width < MIN_TRIG) begin
            trig_width <= trig_width + 32'd1;
          end
        end

        BURST: begin
          if (cnt == BURST_LAST) begin
            state <= ECHO;
            cnt   <= '0;
            echo  <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ECHO: begin
          if (cnt == echo_last) begin
            state      <= HOLDOFF;
            cnt        <= '0;
            echo       <= 1'b0;
            meas_count <= meas_count + 16'd1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        HOLDOFF: begin
          if (cnt == HOLDOFF_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          echo  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
